// File: rtl/monitor_readout_if.sv
// Readout request and bin-data stream bundle between host and monitor_readout_ctrl.
// Handshake: a word moves on any cycle with dout_valid && dout_ready; while dout_ready=0, dout/dout_valid/dout_last hold.
interface monitor_readout_if #(
  parameter int CNT_W = 16
);
  logic             rd_req;
  logic [1:0]       rd_bank;
  logic [CNT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_last;
  logic             dout_ready;

  modport master (
    output rd_req, rd_bank, dout_ready,
    input  dout, dout_valid, dout_last
  );

  modport slave (
    input  rd_req, rd_bank, dout_ready,
    output dout, dout_valid, dout_last
  );
endinterface

// File: rtl/monitor_readout_ctrl.sv
// Snapshots four live histogram banks and streams one selected bank bin by bin.
// Optional macro MON_READOUT_CLEAR_EN: the DONE cycle zeroes the bank just streamed.
module monitor_readout_ctrl #(
  parameter int NUM_BINS = 16,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      end_program,
  input  logic                      run_program,
  input  logic                      active_program,
  input  logic [NUM_BINS*CNT_W-1:0] addr_mon_flat,
  input  logic [NUM_BINS*CNT_W-1:0] addr_fifo_mon_flat,
  input  logic [NUM_BINS*CNT_W-1:0] vctr_mon_flat,
  input  logic [NUM_BINS*CNT_W-1:0] vctr_fifo_mon_flat,
  input  logic                      snap_req,
  monitor_readout_if.slave          rd,
  output logic                      busy,
  output logic                      snap_valid,
  output logic [1:0]                state_dbg
);
  localparam int IDX_W = $clog2(NUM_BINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SNAP = 2'd1, SEND = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       bank_q, bank_d;
  logic             snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0] snap_q [4][NUM_BINS];
  logic [CNT_W-1:0] snap_d [4][NUM_BINS];
  logic [NUM_BINS*CNT_W-1:0] live [4];

  assign live[0] = addr_mon_flat;
  assign live[1] = addr_fifo_mon_flat;
  assign live[2] = vctr_mon_flat;
  assign live[3] = vctr_fifo_mon_flat;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      bank_q       <= '0;
      snap_valid_q <= 1'b0;
      snap_q       <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      bank_q       <= bank_d;
      snap_valid_q <= snap_valid_d;
      snap_q       <= snap_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | end_program | snap_req;
    idx_d        = idx_q;
    bank_d       = bank_q;
    snap_valid_d = snap_valid_q;
    snap_d       = snap_q;
    // Program start invalidates the snapshot; a SNAP this cycle overrides below.
    if (run_program && !active_program) snap_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_d) begin
          state_d = SNAP;
        end else if (rd.rd_req) begin
          bank_d  = rd.rd_bank;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SNAP: begin
        for (int b = 0; b < 4; b++) begin
          for (int k = 0; k < NUM_BINS; k++) begin
            snap_d[b][k] = live[b][k*CNT_W +: CNT_W];
          end
        end
        snap_valid_d = 1'b1;
        pending_d    = end_program | snap_req;
        state_d      = IDLE;
      end
      SEND: begin
        if (rd.dout_ready) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
`ifdef MON_READOUT_CLEAR_EN
        for (int k = 0; k < NUM_BINS; k++) begin
          snap_d[bank_q][k] = '0;
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd.dout       = '0;
    rd.dout_valid = 1'b0;
    rd.dout_last  = 1'b0;
    if (state_q == SEND) begin
      rd.dout       = snap_q[bank_q][idx_q];
      rd.dout_valid = 1'b1;
      rd.dout_last  = (idx_q == LAST_IDX);
    end
  end

  assign busy       = (state_q != IDLE);
  assign snap_valid = snap_valid_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_monitor_readout_ctrl.sv
// Randomized bench for monitor_readout_ctrl: a snapshot/readout model feeds an expected queue checked by a stream monitor.
module tb_monitor_readout_ctrl;
  localparam int NB = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, end_program, run_program, active_program, snap_req;
  logic busy, snap_valid;
  logic [1:0] state_dbg;
  logic [NB*CW-1:0] live_flat [4];

  monitor_readout_if #(.CNT_W(CW)) rd_if ();

  monitor_readout_ctrl #(.NUM_BINS(NB), .CNT_W(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .end_program        (end_program),
    .run_program        (run_program),
    .active_program     (active_program),
    .addr_mon_flat      (live_flat[0]),
    .addr_fifo_mon_flat (live_flat[1]),
    .vctr_mon_flat      (live_flat[2]),
    .vctr_fifo_mon_flat (live_flat[3]),
    .snap_req           (snap_req),
    .rd                 (rd_if.slave),
    .busy               (busy),
    .snap_valid         (snap_valid),
    .state_dbg          (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [CW:0] exp_q [$];
  int pop_cnt = 0;
  logic [CW-1:0] m_snap [4][NB];
  logic m_valid;
  int ready_mode = 0;
  bit hold_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor: pops one expected word per transfer and checks hold-while-stalled.
  initial begin
    logic stalled = 1'b0;
    logic [CW-1:0] prev_dout = '0;
    logic prev_last = 1'b0;
    logic [CW:0] e;
    forever begin
      @(negedge clk);
      if (stalled) begin
        check("stall_valid", 32'(rd_if.dout_valid), 32'd1);
        check("stall_dout", 32'(rd_if.dout), 32'(prev_dout));
        check("stall_last", 32'(rd_if.dout_last), 32'(prev_last));
      end
      if (rd_if.dout_valid && rd_if.dout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", rd_if.dout);
        end else begin
          e = exp_q.pop_front();
          check("dout", 32'(rd_if.dout), 32'(e[CW-1:0]));
          check("dout_last", 32'(rd_if.dout_last), 32'(e[CW]));
        end
        pop_cnt++;
      end
      stalled   = rd_if.dout_valid && !rd_if.dout_ready && reset;
      prev_dout = rd_if.dout;
      prev_last = rd_if.dout_last;
    end
  end

  // Ready driver: always-on, alternating, or random backpressure.
  initial begin
    rd_if.dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_ready)           rd_if.dout_ready = 1'b0;
      else if (ready_mode == 0) rd_if.dout_ready = 1'b1;
      else if (ready_mode == 1) rd_if.dout_ready = ~rd_if.dout_ready;
      else                      rd_if.dout_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic model_snapshot();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < NB; k++) m_snap[b][k] = live_flat[b][k*CW +: CW];
    m_valid = 1'b1;
  endtask

  task automatic model_clear_all();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < NB; k++) m_snap[b][k] = '0;
    m_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int low = 0;
    int n = 0;
    while (low < 2 && n < 200) begin
      tick();
      n++;
      low = busy ? 0 : low + 1;
    end
    if (low < 2) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=busy required=idle");
    end
  endtask

  // inj: 0 none, 1 snap_req at bin 5, 2 rd_req at cycle 3, 3 reset at bin 7.
  task automatic read_bank(input int b, input int mode, input int inj);
    int start, cycles;
    bit sent;
    ready_mode = mode;
    tick();
    tick();
    for (int k = 0; k < NB; k++) exp_q.push_back({(k == NB - 1), m_snap[b][k]});
    start = pop_cnt;
    rd_if.rd_req  = 1'b1;
    rd_if.rd_bank = 2'(b);
    tick();
    rd_if.rd_req  = 1'b0;
    rd_if.rd_bank = 2'($urandom_range(0, 3));
    check("first_valid_latency", 32'(rd_if.dout_valid), 32'd1);
    cycles = 0;
    sent = 0;
    while (busy && cycles < 500) begin
      snap_req     = 1'b0;
      rd_if.rd_req = 1'b0;
      if (inj == 1 && !sent && pop_cnt - start == 5) begin
        snap_req = 1'b1;
        sent = 1;
      end
      if (inj == 2 && cycles == 3) begin
        rd_if.rd_req  = 1'b1;
        rd_if.rd_bank = 2'((b + 1) % 4);
      end
      if (inj == 3 && pop_cnt - start == 7) begin
        hold_ready = 1;
        reset = 1'b0;
        exp_q.delete();
        tick();
        check("abort_valid", 32'(rd_if.dout_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_snap_valid", 32'(snap_valid), 32'd0);
        reset = 1'b1;
        hold_ready = 0;
        model_clear_all();
        tick();
        return;
      end
      cycles++;
      tick();
    end
    snap_req     = 1'b0;
    rd_if.rd_req = 1'b0;
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout actual=busy required=idle");
    end
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    if (mode == 0) check("stream_busy_cycles", 32'(cycles), 32'(NB + 1));
`ifdef MON_READOUT_CLEAR_EN
    for (int k = 0; k < NB; k++) m_snap[b][k] = '0;
`endif
    if (inj == 1) model_snapshot();
    wait_idle();
  endtask

  initial begin
    reset = 1'b0;
    end_program = 1'b0;
    run_program = 1'b0;
    active_program = 1'b0;
    snap_req = 1'b0;
    rd_if.rd_req = 1'b0;
    rd_if.rd_bank = 2'd0;
    for (int b = 0; b < 4; b++) live_flat[b] = '0;
    model_clear_all();
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(rd_if.dout_valid), 32'd0);
    check("reset_last", 32'(rd_if.dout_last), 32'd0);
    check("reset_dout", 32'(rd_if.dout), 32'd0);
    check("reset_snap_valid", 32'(snap_valid), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    tick();

    read_bank(0, 0, 0);

    for (int k = 0; k < NB; k++) live_flat[0][k*CW +: CW] = CW'(k + 1);
    for (int b = 1; b < 4; b++)
      for (int k = 0; k < NB; k++) live_flat[b][k*CW +: CW] = CW'($urandom);
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
    wait_idle();
    model_snapshot();
    check("snap_valid_after_end", 32'(snap_valid), 32'(m_valid));

    read_bank(0, 0, 0);
    read_bank(0, 1, 0);
    read_bank(2, 2, 0);

    for (int b = 0; b < 4; b++)
      for (int k = 0; k < NB; k++) live_flat[b][k*CW +: CW] = CW'($urandom);
    read_bank(2, 0, 1);
    read_bank(2, 0, 0);

    read_bank(1, 0, 2);
    repeat (NB + 4) begin
      tick();
      check("no_second_stream", 32'(busy), 32'd0);
    end

    read_bank(3, 0, 0);
    read_bank(3, 2, 0);
    read_bank(1, 0, 0);

    run_program = 1'b1;
    tick();
    run_program = 1'b0;
    m_valid = 1'b0;
    tick();
    check("snap_valid_prog_start", 32'(snap_valid), 32'(m_valid));
    read_bank(0, 0, 0);

    for (int b = 0; b < 4; b++)
      for (int k = 0; k < NB; k++) live_flat[b][k*CW +: CW] = CW'($urandom);
    run_program = 1'b1;
    end_program = 1'b1;
    tick();
    run_program = 1'b0;
    end_program = 1'b0;
    wait_idle();
    model_snapshot();
    check("snap_valid_start_and_snap", 32'(snap_valid), 32'(m_valid));

    read_bank(0, 1, 3);
    read_bank(0, 0, 0);
    check("snap_valid_after_abort", 32'(snap_valid), 32'(m_valid));
    read_bank(3, 2, 0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/monitor_readout_ctrl.md
MONITOR_READOUT_CTRL -- requirements
Module: monitor_readout_ctrl

Interface
REQ-001 SHALL have parameter NUM_BINS, default 16: bins per histogram bank, power of two, 2..64.
REQ-002 SHALL have parameter CNT_W, default 16: width of each bin counter.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port end_program, input, 1: program end pulse; triggers automatic snapshot.
REQ-006 SHALL have ports run_program and active_program, input, 1 each: run_program && !active_program marks program start.
REQ-007 SHALL have ports addr_mon_flat, addr_fifo_mon_flat, vctr_mon_flat and vctr_fifo_mon_flat, input, NUM_BINS*CNT_W each: live histogram banks 0..3; bin k occupies bits [k*CNT_W +: CNT_W].
REQ-008 SHALL have port snap_req, input, 1: host-requested snapshot pulse.
REQ-009 SHALL have port rd_req, input, 1, and port rd_bank, input, 2: start a readout of the selected bank.
REQ-010 SHALL have ports dout, output, CNT_W; dout_valid, output, 1; dout_last, output, 1; and dout_ready, input, 1: bin data stream.
REQ-011 SHALL have ports busy, output, 1, and snap_valid, output, 1.

Function
REQ-012 SHALL implement states IDLE, SNAP, SEND and DONE.
REQ-013 In IDLE, a pending snapshot SHALL take priority over rd_req and go to SNAP; otherwise rd_req SHALL latch rd_bank, set bin index 0 and go to SEND.
REQ-014 SNAP SHALL last exactly 1 cycle: it copies all four live banks into snapshot registers, sets snap_valid=1, clears the pending flag and returns to IDLE.
REQ-015 A snapshot SHALL become pending on end_program=1 or snap_req=1 in any state.
REQ-016 A snapshot that becomes pending in SEND or DONE SHALL be serviced only after return to IDLE.
REQ-017 In SEND, dout SHALL equal the snapshot bin at the current index of the latched bank, with dout_valid=1.
REQ-018 The index SHALL advance only on a cycle with dout_valid && dout_ready.
REQ-019 dout and dout_valid SHALL stay stable while dout_ready=0.
REQ-020 dout_last SHALL be 1 only in SEND when index = NUM_BINS-1.
REQ-021 A transfer with dout_last=1 SHALL move SEND to DONE; DONE SHALL return to IDLE after 1 cycle.
REQ-022 Latency: the first dout_valid SHALL assert 1 cycle after rd_req is accepted in IDLE.
REQ-023 rd_req SHALL be ignored outside IDLE and while a snapshot is pending; it is not queued.
REQ-024 rd_bank SHALL be sampled only at acceptance; later changes SHALL not affect the current stream.
REQ-025 A readout with snap_valid=0 SHALL still stream NUM_BINS words, each 0.
REQ-026 busy SHALL be 1 in SNAP, SEND and DONE, and 0 in IDLE.
REQ-027 On program start (REQ-006), snap_valid SHALL clear to 0. Snapshot data SHALL be retained, and a snapshot taken in the same cycle SHALL take precedence, leaving snap_valid=1.
REQ-028 The index SHALL be log2(NUM_BINS) bits wide and SHALL never wrap past NUM_BINS-1.

Reset
REQ-029 With reset=0 at a clock edge, the state SHALL be IDLE and the following SHALL be 0: dout, dout_valid, dout_last, busy, snap_valid, pending flag, index, latched bank and all snapshot registers.
REQ-030 Reset during SEND SHALL abort the stream, deassert dout_valid on the next cycle and not be followed by any DONE cycle.

Configuration
REQ-031 Macro MON_READOUT_CLEAR_EN SHALL select clear-on-read.
REQ-032 With MON_READOUT_CLEAR_EN defined, the DONE cycle SHALL zero all snapshot bins of the bank just streamed; the other banks and snap_valid SHALL be unchanged.
REQ-033 With MON_READOUT_CLEAR_EN undefined, snapshot contents SHALL change only in SNAP or on reset, so repeated reads return identical data.

Verification
REQ-034 Live bank 0 bin k = k+1, end_program pulse, rd_req with rd_bank=0, dout_ready=1 -> 16 words 1..16 on consecutive cycles, dout_last on word 16, snap_valid=1.
REQ-035 Same as REQ-034 with dout_ready toggling every other cycle -> identical word sequence, dout held stable while stalled, no word skipped.
REQ-036 snap_req while streaming bin 5 of bank 2 -> stream completes with the old data, then one SNAP cycle; the next read returns the new values.
REQ-037 rd_req while busy=1 -> ignored, with no second stream after DONE.
REQ-038 With MON_READOUT_CLEAR_EN, read bank 3 twice -> the second read is all zeros and a read of bank 1 is unchanged; without it, both reads of bank 3 are identical.
REQ-039 reset=0 at bin 7 of a stream -> the next cycle has dout_valid=0, busy=0, snap_valid=0, and a following read returns all zeros.
